dma_status_update_block: RTL and testbench

Downstream stage of the scatter-gather write path. Accepts completion status entries pushed by the DMA write block, buffers them in a local FIFO, and writes each one back as a status word into its descriptor in memory through a 32-bit AVMM write master. Counts completed descriptors and raises a completion interrupt. Status entry format: `{owned_by_hw, desc_id[7:0], bytes_transferred[15:0]}`.

---
 rtl/dma_pkg.sv | 50 +++++
 rtl/dma_status_fifo.sv | 74 +++++++
 rtl/dma_status_update_block.sv | 130 +++++++++++++
 tb/tb_dma_status_update_block.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the scatter-gather status write-back path:
// status entry layout, FSM encodings, status word bit positions.
package dma_pkg;

    // Status entry: {owned_by_hw, desc_id[7:0], bytes_transferred[15:0]}
    localparam int ENTRY_W   = 25;
    localparam int BYTES_W   = 16;
    localparam int ID_W      = 8;
    localparam int BYTES_LSB = 0;
    localparam int ID_LSB    = 16;
    localparam int OWN_BIT   = 24;

    // FSM encodings
    localparam logic [2:0] ST_IDLE      = 3'b000;
    localparam logic [2:0] ST_RD_FIFO   = 3'b001;
    localparam logic [2:0] ST_LD_STATUS = 3'b010;
    localparam logic [2:0] ST_WR_STATUS = 3'b011;
    localparam logic [2:0] ST_DONE      = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_RD_FIFO   = ST_RD_FIFO,
        S_LD_STATUS = ST_LD_STATUS,
        S_WR_STATUS = ST_WR_STATUS,
        S_DONE      = ST_DONE
    } state_e;

    // Status word written back into the descriptor
    localparam int STW_OWN_BIT  = 31;
    localparam int STW_DONE_BIT = 30;
    localparam int STW_ERR_BIT  = 29;

    // Descriptor geometry defaults
    localparam int DEF_DESC_SIZE_LOG2 = 5;
    localparam int DEF_STATUS_OFFSET  = 28;

    // Build the write-back word: ownership returned to SW, done set,
    // error set when the entry completed on a SW-owned descriptor.
    function automatic logic [31:0] make_status_word(input logic [ENTRY_W-1:0] entry);
        logic [31:0] w;
        w                          = '0;
        w[STW_OWN_BIT]             = 1'b0;
        w[STW_DONE_BIT]            = 1'b1;
        w[STW_ERR_BIT]             = ~entry[OWN_BIT];
        w[ID_LSB +: ID_W]          = entry[ID_LSB +: ID_W];
        w[BYTES_LSB +: BYTES_W]    = entry[BYTES_LSB +: BYTES_W];
        return w;
    endfunction

endpackage

// File: rtl/dma_status_fifo.sv
// Status entry FIFO: inferred RAM, registered (non show-ahead) read,
// synchronous clear, write dropped when full.
module dma_status_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_LVL = 12,
    parameter int WIDTH           = ENTRY_W
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_LVL    = (AW+1)'(ALMOST_FULL_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      usedw_q,  usedw_d;
    logic             wr_en;
    logic             rd_en;

    assign empty       = (usedw_q == '0);
    assign full        = (usedw_q == DEPTH_LVL);
    assign almost_full = (usedw_q >= AF_LVL);
    assign q           = q_q;

    assign wr_en = wrreq & ~full;
    assign rd_en = rdreq & ~empty;

    // Pointer and fill-level next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
        endcase
    end

    // Pointer and fill-level registers, flushed by sclr
    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end

    // RAM array with registered read port; q valid the cycle after rdreq
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= data;
        if (rd_en) q_q <= mem[rd_ptr_q];
    end

endmodule

// File: rtl/dma_status_update_block.sv
// Status write-back stage: drains status entries from a local FIFO and
// writes each as a status word into its descriptor over AVMM; counts
// completions and raises a level completion interrupt.
module dma_status_update_block
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int ALMOST_FULL_LVL = 12,
    parameter int DESC_SIZE_LOG2  = DEF_DESC_SIZE_LOG2,
    parameter int STATUS_OFFSET   = DEF_STATUS_OFFSET
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dma_status_fifo_wr_req_i,
    input  logic [ENTRY_W-1:0] dma_status_fifo_data_i,
    output logic               dma_status_fifo_almost_full_o,
    input  logic [31:0]        desc_base_addr_i,
    output logic [31:0]        st_master_addr_o,
    output logic [31:0]        st_master_data_o,
    output logic               st_master_o,
    input  logic               st_master_wait_req_i,
    input  logic               irq_enable_i,
    input  logic               irq_clear_i,
    output logic               irq_o,
    output logic [15:0]        desc_done_count_o,
    output logic               status_overflow_o
);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               st_master_q, st_master_d;
    logic [15:0]        count_q, count_d;
    logic               irq_q, irq_d;
    logic               ovf_q, ovf_d;

    logic               fifo_rdreq;
    logic [ENTRY_W-1:0] fifo_q;
    logic               fifo_empty;
    logic               fifo_full;

    dma_status_fifo #(
        .DEPTH           (FIFO_DEPTH),
        .ALMOST_FULL_LVL (ALMOST_FULL_LVL),
        .WIDTH           (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .sclr        (reset),
        .wrreq       (dma_status_fifo_wr_req_i),
        .data        (dma_status_fifo_data_i),
        .rdreq       (fifo_rdreq),
        .q           (fifo_q),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .almost_full (dma_status_fifo_almost_full_o)
    );

    assign fifo_rdreq        = (state_q == S_RD_FIFO);
    assign st_master_addr_o  = addr_q;
    assign st_master_data_o  = data_q;
    assign st_master_o       = st_master_q;
    assign desc_done_count_o = count_q;
    assign irq_o             = irq_q;
    assign status_overflow_o = ovf_q;

    // FSM next state, datapath capture, counter, irq and overflow
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        irq_d   = irq_q;
        ovf_d   = ovf_q | (dma_status_fifo_wr_req_i & fifo_full);

        // Clear first so a same-cycle set in DONE takes priority
        if (irq_clear_i) irq_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_RD_FIFO;
            end
            S_RD_FIFO: begin
                state_d = S_LD_STATUS;
            end
            S_LD_STATUS: begin
                addr_d  = desc_base_addr_i
                        + (32'(fifo_q[ID_LSB +: ID_W]) << DESC_SIZE_LOG2)
                        + 32'(STATUS_OFFSET);
                data_d  = make_status_word(fifo_q);
                state_d = S_WR_STATUS;
            end
            S_WR_STATUS: begin
                if (!st_master_wait_req_i) state_d = S_DONE;
            end
            S_DONE: begin
                count_d = count_q + 16'd1;
                if (irq_enable_i) irq_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Write strobe is a registered decode of the upcoming state
        st_master_d = (state_d == S_WR_STATUS);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            st_master_q <= 1'b0;
            count_q     <= '0;
            irq_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            st_master_q <= st_master_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dma_status_update_block.sv
// Self-checking bench for dma_status_update_block: scoreboard of expected
// {addr,data} writes, monitor compares every accepted AVMM write.
module tb_dma_status_update_block;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_req = 1'b0;
    logic [24:0] wr_data = '0;
    logic        almost_full;
    logic [31:0] base_addr = '0;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_write;
    logic        m_wait = 1'b0;
    logic        irq_en = 1'b0;
    logic        irq_clr = 1'b0;
    logic        irq;
    logic [15:0] done_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int writes   = 0;
    int hi_cycles = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    dma_status_update_block dut (
        .clk                           (clk),
        .reset                         (reset),
        .dma_status_fifo_wr_req_i      (wr_req),
        .dma_status_fifo_data_i        (wr_data),
        .dma_status_fifo_almost_full_o (almost_full),
        .desc_base_addr_i              (base_addr),
        .st_master_addr_o              (m_addr),
        .st_master_data_o              (m_data),
        .st_master_o                   (m_write),
        .st_master_wait_req_i          (m_wait),
        .irq_enable_i                  (irq_en),
        .irq_clear_i                   (irq_clr),
        .irq_o                         (irq),
        .desc_done_count_o             (done_cnt),
        .status_overflow_o             (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] base, input logic [24:0] e);
        logic [31:0] a, d;
        a = base + ({24'h0, e[23:16]} * 32'd32) + 32'd28;
        d = {2'b01, ~e[24], 5'b0, e[23:16], e[15:0]};
        return {a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; scoreboard entry only when the FIFO will accept it
    task automatic push(input logic [24:0] e, input bit accept);
        wr_req  = 1'b1;
        wr_data = e;
        if (accept) sb.push_back(model(base_addr, e));
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 3000;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check({tag, "_drain_timeout"}, 64'(sb.size()), 64'd0);
        repeat (3) tick();
    endtask

    // Monitor: every write-strobe cycle compares addr/data to scoreboard head
    always @(negedge clk) begin
        if (!reset && m_write) begin
            hi_cycles++;
            if (sb.size() == 0) begin
                check("unexpected_write", {m_addr, m_data}, 64'h0);
            end else begin
                check($sformatf("write%0d", writes), {m_addr, m_data}, sb[0]);
                if (!m_wait) begin
                    void'(sb.pop_front());
                    writes++;
                end
            end
        end
    end

    initial begin
        int w0;
        logic [15:0] c0;

        // Reset state
        repeat (3) tick();
        check("rst_write", 64'(m_write), 64'd0);
        check("rst_addr",  64'(m_addr), 64'd0);
        check("rst_data",  64'(m_data), 64'd0);
        check("rst_irq",   64'(irq), 64'd0);
        check("rst_cnt",   64'(done_cnt), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_af",    64'(almost_full), 64'd0);
        reset = 1'b0;
        tick();

        // Single entry with cycle-exact timing
        base_addr = 32'h1000_0000;
        irq_en = 1'b1;
        push({1'b1, 8'h05, 16'h0100}, 1'b1);   // edge N
        tick(); tick();
        check("single_strobe_n2", 64'(m_write), 64'd0);
        tick();
        check("single_strobe_n3", 64'(m_write), 64'd1);
        check("single_addr", 64'(m_addr), 64'h1000_00BC);
        check("single_data", 64'(m_data), 64'h4005_0100);
        tick();
        check("single_strobe_n4", 64'(m_write), 64'd0);
        check("single_cnt_n4", 64'(done_cnt), 64'd0);
        tick();
        check("single_cnt_n5", 64'(done_cnt), 64'd1);
        check("single_irq_n5", 64'(irq), 64'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("irq_cleared", 64'(irq), 64'd0);

        // Waitrequest held for 3 cycles
        m_wait = 1'b1;
        hi_cycles = 0;
        push({1'b1, 8'h10, 16'h1234}, 1'b1);
        repeat (6) tick();
        m_wait = 1'b0;
        repeat (3) tick();
        check("wait_hi_cycles", 64'(hi_cycles), 64'd4);
        check("wait_cnt", 64'(done_cnt), 64'd2);

        // Error entry on SW-owned descriptor
        base_addr = 32'h0;
        push({1'b0, 8'hFF, 16'h0020}, 1'b1);
        repeat (3) tick();
        check("err_addr", 64'(m_addr), 64'h0000_1FFC);
        check("err_data", 64'(m_data), 64'h60FF_0020);
        drain("err");
        check("err_cnt", 64'(done_cnt), 64'd3);

        // Backpressure: one entry stalls in WR_STATUS, then fill the FIFO
        m_wait = 1'b1;
        base_addr = 32'h2000_0000;
        w0 = writes;
        c0 = done_cnt;
        push({1'b1, 8'h40, 16'h0001}, 1'b1);
        repeat (4) tick();
        for (int k = 1; k <= 17; k++) begin
            push({1'b1, 8'(8'h40 + k), 16'(k * 3)}, k <= 16);
            if (k == 11 || k == 12)
                check($sformatf("bp_af_%0d", k), 64'(almost_full), 64'(k >= 12));
            if (k == 16 || k == 17)
                check($sformatf("bp_ovf_%0d", k), 64'(overflow), 64'(k >= 17));
        end
        m_wait = 1'b0;
        drain("bp");
        check("bp_writes", 64'(writes - w0), 64'd17);
        check("bp_cnt", 64'(done_cnt - c0), 64'd17);
        check("bp_af_after", 64'(almost_full), 64'd0);
        check("bp_ovf_sticky", 64'(overflow), 64'd1);

        // IRQ: set and clear in the same cycle, set wins
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        push({1'b1, 8'h22, 16'h0044}, 1'b1);   // edge N
        repeat (4) tick();                     // DONE during this cycle
        irq_clr = 1'b1;
        tick();
        check("irq_set_wins", 64'(irq), 64'd1);
        tick();
        irq_clr = 1'b0;
        check("irq_clear_next", 64'(irq), 64'd0);

        // IRQ disabled: count advances, irq stays low
        irq_en = 1'b0;
        c0 = done_cnt;
        push({1'b1, 8'h33, 16'h0055}, 1'b1);
        drain("noirq");
        check("noirq_irq", 64'(irq), 64'd0);
        check("noirq_cnt", 64'(done_cnt - c0), 64'd1);

        // Reset in the middle of WR_STATUS
        m_wait = 1'b1;
        push({1'b1, 8'h60, 16'h0600}, 1'b1);
        push({1'b1, 8'h61, 16'h0610}, 1'b1);
        begin
            int budget;
            budget = 20;
            while (!m_write && budget > 0) begin tick(); budget--; end
            check("mid_reach_wr", 64'(m_write), 64'd1);
        end
        reset = 1'b1;
        tick();
        check("mid_rst_write", 64'(m_write), 64'd0);
        check("mid_rst_addr",  64'(m_addr), 64'd0);
        check("mid_rst_data",  64'(m_data), 64'd0);
        check("mid_rst_cnt",   64'(done_cnt), 64'd0);
        check("mid_rst_ovf",   64'(overflow), 64'd0);
        check("mid_rst_irq",   64'(irq), 64'd0);
        reset = 1'b0;
        sb.delete();
        m_wait = 1'b0;
        w0 = writes;
        repeat (20) tick();
        check("mid_no_write", 64'(writes - w0), 64'd0);
        check("mid_cnt_after", 64'(done_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
